// File: rtl/decoder_n_scan_if.sv
// rtl/decoder_n_scan_if.sv - select/strobe bundle between a controller and decoder_n_scan
interface decoder_n_scan_if #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 2 ** IN_W
);
    logic                E;
    logic                mode;
    logic [IN_W-1:0]     In;
    logic [NUM_OUT-1:0]  Out;
    logic [IN_W-1:0]     Idx;
    logic                wrap;
    logic                err;

    modport master (
        output E, mode, In,
        input  Out, Idx, wrap, err
    );

    modport slave (
        input  E, mode, In,
        output Out, Idx, wrap, err
    );
endinterface

// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered one-hot decoder with enable, DIRECT decode and autonomous SCAN strobing
module decoder_n_scan #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 2 ** IN_W,
    parameter int DWELL   = 4,
    parameter int ACT_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    decoder_n_scan_if.slave  bus
);
    localparam int                 DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [IN_W-1:0]    IDX_LAST   = IN_W'(NUM_OUT - 1);
    localparam logic [IN_W:0]      NUM_OUT_W  = (IN_W + 1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] INACTIVE   = {NUM_OUT{(ACT_LOW != 0)}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t          st;
    logic [DW_W-1:0] dwell;
    // Set while there is no scan position worth resuming (after reset or any DIRECT cycle).
    logic            fresh;

    logic [DW_W-1:0] step_dwell;
    logic [IN_W-1:0] step_idx;
    logic            step_wrap;
    logic            in_ok;

    function automatic logic [NUM_OUT-1:0] drive_line(input logic [IN_W-1:0] idx);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (idx == IN_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return (ACT_LOW != 0) ? ~v : v;
    endfunction

    assign in_ok = ({1'b0, bus.In} < NUM_OUT_W);

    // One scan tick from the current position; also used when resuming after a pause.
    always_comb begin
        step_dwell = dwell;
        step_idx   = bus.Idx;
        step_wrap  = 1'b0;
        if (dwell == DWELL_LAST) begin
            step_dwell = '0;
            if (bus.Idx >= IDX_LAST) begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end else begin
                step_idx = bus.Idx + 1'b1;
            end
        end else begin
            step_dwell = dwell + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            bus.Idx  <= '0;
            dwell    <= '0;
            bus.wrap <= 1'b0;
            bus.err  <= 1'b0;
            bus.Out  <= INACTIVE;
            fresh    <= 1'b1;
        end else begin
            bus.wrap <= 1'b0;
            bus.err  <= 1'b0;
            if (!bus.E) begin
                st      <= ST_IDLE;
                bus.Out <= INACTIVE;
            end else if (!bus.mode) begin
                st      <= ST_DIRECT;
                bus.Idx <= bus.In;
                dwell   <= '0;
                fresh   <= 1'b1;
                bus.Out <= in_ok ? drive_line(bus.In) : INACTIVE;
                bus.err <= ~in_ok;
            end else begin
                st    <= ST_SCAN;
                fresh <= 1'b0;
                if (st != ST_SCAN && fresh) begin
                    bus.Idx <= '0;
                    dwell   <= '0;
                    bus.Out <= drive_line('0);
                end else begin
                    bus.Idx  <= step_idx;
                    dwell    <= step_dwell;
                    bus.wrap <= step_wrap;
                    bus.Out  <= drive_line(step_idx);
                end
            end
        end
    end
endmodule
